// File: rtl/pwm_pkg.sv
// Shared encodings and helpers for the PWM source block: actuator select codes
// and the order in which the MODE button walks through them.
package pwm_pkg;

    typedef enum logic [1:0] {
        SEL_OFF      = 2'b00,
        SEL_MOTORRED = 2'b01,
        SEL_MOTOR_DC = 2'b11,
        SEL_LED      = 2'b10
    } sel_e;

    // OFF -> MOTORREDUCTOR -> MOTOR_DC -> LED -> OFF
    function automatic sel_e sel_next(input sel_e cur);
        sel_e nxt;
        case (cur)
            SEL_OFF:      nxt = SEL_MOTORRED;
            SEL_MOTORRED: nxt = SEL_MOTOR_DC;
            SEL_MOTOR_DC: nxt = SEL_LED;
            SEL_LED:      nxt = SEL_OFF;
            default:      nxt = SEL_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/boton_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level counter and a
// single-cycle pulse on every accepted rising level.
module boton_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 50000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic LEVEL,
    output logic PRESS
);

    localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized input disagrees with the
    // accepted level; the DEBOUNCE_CYC-th consecutive disagreement flips it.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= BTN;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign LEVEL = level_q;
    assign PRESS = press_q;

endmodule

// File: rtl/pwm_sel_gen.sv
// PWM source for the output router: debounced MODE/UP/DOWN buttons drive the
// actuator select FSM and a saturating duty register feeding a shadowed PWM.
module pwm_sel_gen
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD_CYC   = 1000,
    parameter int unsigned DUTY_STEP    = 100,
    parameter int unsigned DEBOUNCE_CYC = 50000,
    localparam int unsigned CW          = $clog2(PERIOD_CYC + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          BTN_MODE,
    input  logic          BTN_UP,
    input  logic          BTN_DOWN,
    output logic          FREC,
    output logic [1:0]    BOTON_SEL,
    output logic [CW-1:0] DUTY
);

    localparam logic [CW:0]   STEP_W   = (CW + 1)'(DUTY_STEP);
    localparam logic [CW:0]   PERIOD_W = (CW + 1)'(PERIOD_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYC - 1);

    logic       press_mode, press_up, press_down;
    // Accepted levels are not needed here; only press pulses drive the block.
    logic [2:0] unused_level;

    boton_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb_mode (
        .CLK  (CLK),
        .RST_N(RST_N),
        .BTN  (BTN_MODE),
        .LEVEL(unused_level[0]),
        .PRESS(press_mode)
    );

    boton_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb_up (
        .CLK  (CLK),
        .RST_N(RST_N),
        .BTN  (BTN_UP),
        .LEVEL(unused_level[1]),
        .PRESS(press_up)
    );

    boton_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb_down (
        .CLK  (CLK),
        .RST_N(RST_N),
        .BTN  (BTN_DOWN),
        .LEVEL(unused_level[2]),
        .PRESS(press_down)
    );

    sel_e          sel_q, sel_d;
    logic [CW-1:0] duty_q, duty_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] duty_act_q, duty_act_d;
    logic          frec_q, frec_d;

    always_comb begin
        sel_d = sel_q;
        if (press_mode) begin
            sel_d = sel_next(sel_q);
        end
    end

    // One extra bit keeps both the saturating add and subtract from wrapping.
    logic [CW:0] duty_w, duty_inc, duty_dec;

    always_comb begin
        duty_w   = {1'b0, duty_q};
        duty_inc = duty_w + STEP_W;
        duty_dec = duty_w - STEP_W;
        duty_d   = duty_q;
        if (press_up && !press_down) begin
            duty_d = (duty_inc > PERIOD_W) ? PERIOD_W[CW-1:0] : duty_inc[CW-1:0];
        end else if (press_down && !press_up) begin
            duty_d = (duty_w < STEP_W) ? '0 : duty_dec[CW-1:0];
        end
    end

    // Shadow loads only at the last count so a period never changes shape midway.
    always_comb begin
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        duty_act_d = (cnt_q == CNT_LAST) ? duty_q : duty_act_q;
        frec_d     = (sel_q != SEL_OFF) && (cnt_q < duty_act_q);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sel_q      <= SEL_OFF;
            duty_q     <= '0;
            cnt_q      <= '0;
            duty_act_q <= '0;
            frec_q     <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            duty_q     <= duty_d;
            cnt_q      <= cnt_d;
            duty_act_q <= duty_act_d;
            frec_q     <= frec_d;
        end
    end

    assign FREC      = frec_q;
    assign BOTON_SEL = sel_q;
    assign DUTY      = duty_q;

endmodule

// File: tb/tb_pwm_sel_gen.sv
// Directed bench for pwm_sel_gen with PERIOD_CYC=10, DUTY_STEP=3, DEBOUNCE_CYC=4.
module tb_pwm_sel_gen;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       BTN_MODE = 1'b1;
    logic       BTN_UP = 1'b1;
    logic       BTN_DOWN = 1'b1;
    logic       FREC;
    logic [1:0] BOTON_SEL;
    logic [3:0] DUTY;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;

    pwm_sel_gen #(
        .PERIOD_CYC  (10),
        .DUTY_STEP   (3),
        .DEBOUNCE_CYC(4)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .BTN_MODE (BTN_MODE),
        .BTN_UP   (BTN_UP),
        .BTN_DOWN (BTN_DOWN),
        .FREC     (FREC),
        .BOTON_SEL(BOTON_SEL),
        .DUTY     (DUTY)
    );

    always #5 CLK = ~CLK;

    // Reference period counter, as the PWM counter should behave.
    always @(posedge CLK) begin
        if (!RST_N) m_cnt <= 0;
        else        m_cnt <= (m_cnt == 9) ? 0 : m_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Raise the given buttons and wait until the resulting update is visible.
    task automatic press_hold(input logic up, input logic dn, input logic md);
        BTN_UP   = up;
        BTN_DOWN = dn;
        BTN_MODE = md;
        tick(7);
    endtask

    task automatic release_all();
        BTN_UP   = 1'b0;
        BTN_DOWN = 1'b0;
        BTN_MODE = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks += 3;
            if (FREC !== 1'b0) begin
                errors++;
                $display("FAIL reset_frec: got %b expected 0", FREC);
            end
            if (BOTON_SEL !== 2'b00) begin
                errors++;
                $display("FAIL reset_sel: got %b expected 00", BOTON_SEL);
            end
            if (DUTY !== 4'd0) begin
                errors++;
                $display("FAIL reset_duty: got %0d expected 0", DUTY);
            end
        end
        RST_N    = 1'b1;
        BTN_MODE = 1'b0;
        BTN_DOWN = 1'b0;
        tick(6);
        checks++;
        if (DUTY !== 4'd0) begin
            errors++;
            $display("FAIL reset_up_early: got %0d expected 0", DUTY);
        end
        tick(1);
        checks++;
        if (DUTY !== 4'd3) begin
            errors++;
            $display("FAIL reset_up_latency: got %0d expected 3", DUTY);
        end
        release_all();
    endtask

    task automatic test_debounce();
        int pat[16];
        pat = '{1, 2, 3, 1, 2, 3, 1, 1, 3, 2, 2, 1, 1, 3, 3, 1};
        for (int i = 0; i < 16; i++) begin
            BTN_UP = (i % 2 == 0);
            tick(pat[i]);
        end
        tick(8);
        checks++;
        if (DUTY !== 4'd3) begin
            errors++;
            $display("FAIL debounce_glitch: got %0d expected 3", DUTY);
        end
        BTN_UP = 1'b1;
        tick(6);
        checks++;
        if (DUTY !== 4'd3) begin
            errors++;
            $display("FAIL debounce_early: got %0d expected 3", DUTY);
        end
        tick(1);
        checks++;
        if (DUTY !== 4'd6) begin
            errors++;
            $display("FAIL debounce_step: got %0d expected 6", DUTY);
        end
        tick(13);
        BTN_UP = 1'b0;
        tick(8);
        checks++;
        if (DUTY !== 4'd6) begin
            errors++;
            $display("FAIL debounce_no_repeat: got %0d expected 6", DUTY);
        end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_sel[5];
        logic [1:0] old_sel;
        logic [1:0] prev_sel;
        exp_sel = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        old_sel = 2'b00;
        for (int i = 0; i < 5; i++) begin
            BTN_MODE = 1'b1;
            for (int c = 0; c < 15; c++) begin
                if (c == 7) BTN_MODE = 1'b0;
                prev_sel = BOTON_SEL;
                tick(1);
                // FREC lags BOTON_SEL by one cycle.
                if (prev_sel == 2'b00) begin
                    checks++;
                    if (FREC !== 1'b0) begin
                        errors++;
                        $display("FAIL mode_off_frec: got %b expected 0", FREC);
                    end
                end
                if (c == 5) begin
                    checks++;
                    if (BOTON_SEL !== old_sel) begin
                        errors++;
                        $display("FAIL mode_early[%0d]: got %b expected %b", i, BOTON_SEL,
                                 old_sel);
                    end
                end
                if (c == 6) begin
                    checks++;
                    if (BOTON_SEL !== exp_sel[i]) begin
                        errors++;
                        $display("FAIL mode_step[%0d]: got %b expected %b", i, BOTON_SEL,
                                 exp_sel[i]);
                    end
                end
            end
            old_sel = exp_sel[i];
        end
        checks++;
        if (DUTY !== 4'd6) begin
            errors++;
            $display("FAIL mode_keeps_duty: got %0d expected 6", DUTY);
        end
    endtask

    task automatic test_saturation();
        int exp_up[5];
        int exp_dn[5];
        exp_up = '{3, 6, 9, 10, 10};
        exp_dn = '{7, 4, 1, 0, 0};
        for (int i = 0; i < 2; i++) begin
            press_hold(1'b0, 1'b1, 1'b0);
            checks++;
            if (DUTY !== 4'(3 - 3 * i)) begin
                errors++;
                $display("FAIL sat_prep[%0d]: got %0d expected %0d", i, DUTY, 3 - 3 * i);
            end
            release_all();
        end
        for (int i = 0; i < 5; i++) begin
            press_hold(1'b1, 1'b0, 1'b0);
            checks++;
            if (DUTY !== 4'(exp_up[i])) begin
                errors++;
                $display("FAIL sat_up[%0d]: got %0d expected %0d", i, DUTY, exp_up[i]);
            end
            release_all();
        end
        for (int i = 0; i < 5; i++) begin
            press_hold(1'b0, 1'b1, 1'b0);
            checks++;
            if (DUTY !== 4'(exp_dn[i])) begin
                errors++;
                $display("FAIL sat_down[%0d]: got %0d expected %0d", i, DUTY, exp_dn[i]);
            end
            release_all();
        end
    endtask

    task automatic test_pwm_shape();
        int n_up[3];
        int n_dn[3];
        int target[3];
        int guard;
        int prev;
        logic exp_f;
        n_up   = '{1, 3, 0};
        n_dn   = '{0, 0, 4};
        target = '{3, 10, 0};
        checks++;
        if (BOTON_SEL !== 2'b01) begin
            errors++;
            $display("FAIL pwm_sel: got %b expected 01", BOTON_SEL);
        end
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < n_up[p]; k++) begin
                press_hold(1'b1, 1'b0, 1'b0);
                release_all();
            end
            for (int k = 0; k < n_dn[p]; k++) begin
                press_hold(1'b0, 1'b1, 1'b0);
                release_all();
            end
            checks++;
            if (DUTY !== 4'(target[p])) begin
                errors++;
                $display("FAIL pwm_duty[%0d]: got %0d expected %0d", p, DUTY, target[p]);
            end
            guard = 0;
            do begin
                tick(1);
                guard++;
            end while (m_cnt != 0 && guard < 30);
            checks++;
            if (m_cnt != 0) begin
                errors++;
                $display("FAIL pwm_wrap_timeout: cnt %0d expected 0", m_cnt);
            end
            tick(1);
            for (int c = 0; c < 20; c++) begin
                prev  = (m_cnt + 9) % 10;
                exp_f = (prev < target[p]);
                checks++;
                if (FREC !== exp_f) begin
                    errors++;
                    $display("FAIL pwm_shape[%0d] cnt %0d: got %b expected %b", p, prev, FREC,
                             exp_f);
                end
                tick(1);
            end
        end
    endtask

    task automatic test_glitch_free();
        int guard;
        int prev;
        logic use_new;
        logic exp_f;
        press_hold(1'b1, 1'b0, 1'b0);
        checks++;
        if (DUTY !== 4'd3) begin
            errors++;
            $display("FAIL gf_prep: got %0d expected 3", DUTY);
        end
        release_all();
        guard = 0;
        do begin
            tick(1);
            guard++;
        end while (m_cnt != 0 && guard < 30);
        guard = 0;
        while (m_cnt != 8 && guard < 30) begin
            tick(1);
            guard++;
        end
        checks++;
        if (m_cnt != 8) begin
            errors++;
            $display("FAIL gf_align_timeout: cnt %0d expected 8", m_cnt);
        end
        // DUTY lands mid-period (cnt = 5); the running period must keep duty 3.
        BTN_UP = 1'b1;
        tick(7);
        checks++;
        if (DUTY !== 4'd6) begin
            errors++;
            $display("FAIL gf_duty: got %0d expected 6", DUTY);
        end
        use_new = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick(1);
            if (m_cnt == 1) use_new = 1'b1;
            prev  = (m_cnt + 9) % 10;
            exp_f = use_new ? (prev < 6) : (prev < 3);
            checks++;
            if (FREC !== exp_f) begin
                errors++;
                $display("FAIL gf_frec cnt %0d: got %b expected %b", prev, FREC, exp_f);
            end
        end
        release_all();
        press_hold(1'b1, 1'b1, 1'b0);
        checks++;
        if (DUTY !== 4'd6) begin
            errors++;
            $display("FAIL simult_up_down: got %0d expected 6", DUTY);
        end
        release_all();
        press_hold(1'b1, 1'b0, 1'b1);
        checks += 2;
        if (DUTY !== 4'd9) begin
            errors++;
            $display("FAIL simult_mode_up_duty: got %0d expected 9", DUTY);
        end
        if (BOTON_SEL !== 2'b11) begin
            errors++;
            $display("FAIL simult_mode_up_sel: got %b expected 11", BOTON_SEL);
        end
        release_all();
    endtask

    task automatic test_reset_mid();
        BTN_UP = 1'b1;
        RST_N  = 1'b0;
        tick(1);
        checks += 3;
        if (FREC !== 1'b0) begin
            errors++;
            $display("FAIL midreset_frec: got %b expected 0", FREC);
        end
        if (BOTON_SEL !== 2'b00) begin
            errors++;
            $display("FAIL midreset_sel: got %b expected 00", BOTON_SEL);
        end
        if (DUTY !== 4'd0) begin
            errors++;
            $display("FAIL midreset_duty: got %0d expected 0", DUTY);
        end
        RST_N = 1'b1;
        release_all();
        checks++;
        if (DUTY !== 4'd0) begin
            errors++;
            $display("FAIL midreset_after: got %0d expected 0", DUTY);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debounce();
        test_mode_cycle();
        test_saturation();
        test_pwm_shape();
        test_glitch_free();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
